// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial I2S lines plus the captured stereo sample bus.
//   master: drives bclk/lrclk/sdata, observes captured samples and status
//   slave : the receiver; samples the serial lines, drives the sample bus
//   bclk, lrclk, sdata      serial bit clock, word select (0 = left), data
//   left_data, right_data   last completed stereo pair
//   sample_valid            one-cycle strobe when the pair updates
//   err_short               one-cycle strobe when a slot ended short
//   locked                  a channel boundary has been seen since reset
interface i2s_rx_if #(
  parameter int unsigned DATA_W = 16
);
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              err_short;
  logic              locked;

  modport master (
    output bclk, lrclk, sdata,
    input  left_data, right_data, sample_valid, err_short, locked
  );

  modport slave (
    input  bclk, lrclk, sdata,
    output left_data, right_data, sample_valid, err_short, locked
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver oversampled on the system clock.
// Deserializes DATA_W bits (MSB first) per channel and presents each
// completed left+right pair with a one-cycle sample_valid strobe.
//   clk    system clock, sole clock of the block
//   rst_n  synchronous active-low reset
//   i2s    serial inputs and registered sample/status outputs (slave side)
module i2s_rx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_rx_if.slave  i2s
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  // Two-flop synchronizers; the extra bclk stage finds rising edges.
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lr_s1_q, lr_s2_q;
  logic sd_s1_q, sd_s2_q;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              chan_q, chan_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] left_data_q, left_data_d;
  logic [DATA_W-1:0] right_data_q, right_data_d;
  logic              sample_valid_q, sample_valid_d;
  logic              err_short_q, err_short_d;

  logic              bclk_rise_c;
  logic              take_c;
  logic              done_c;
  logic [CNT_W-1:0]  cnt_c;
  logic [DATA_W-1:0] word_c;

  assign bclk_rise_c = bclk_s2_q & ~bclk_s3_q;

  // Capture, word completion and slot-boundary handling on each bclk rise.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    chan_d         = chan_q;
    lr_prev_d      = lr_prev_q;
    shift_d        = shift_q;
    left_hold_d    = left_hold_q;
    left_ok_d      = left_ok_q;
    locked_d       = locked_q;
    left_data_d    = left_data_q;
    right_data_d   = right_data_q;
    sample_valid_d = 1'b0;
    err_short_d    = 1'b0;

    // On a boundary this bit still belongs to the slot that is ending.
    take_c = bclk_rise_c && locked_q && (bit_cnt_q < CNT_W'(DATA_W));
    word_c = take_c ? {shift_q[DATA_W-2:0], sd_s2_q} : shift_q;
    cnt_c  = take_c ? (bit_cnt_q + CNT_W'(1)) : bit_cnt_q;
    done_c = take_c && (cnt_c == CNT_W'(DATA_W));

    if (bclk_rise_c) begin
      shift_d   = word_c;
      bit_cnt_d = cnt_c;

      if (done_c) begin
        if (!chan_q) begin
          left_hold_d = word_c;
          left_ok_d   = 1'b1;
        end else if (left_ok_q) begin
          left_data_d    = left_hold_q;
          right_data_d   = word_c;
          sample_valid_d = 1'b1;
          left_ok_d      = 1'b0;
        end
      end

      if (lr_s2_q != lr_prev_q) begin
        // First boundary after reset only locks; later ones flag short slots.
        if (locked_q && (cnt_c < CNT_W'(DATA_W))) begin
          err_short_d = 1'b1;
          if (!chan_q) begin
            left_ok_d = 1'b0;
          end
        end
        bit_cnt_d = '0;
        chan_d    = lr_s2_q;
        lr_prev_d = lr_s2_q;
        locked_d  = 1'b1;
      end
    end
  end

  // State and synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_s1_q      <= 1'b0;
      bclk_s2_q      <= 1'b0;
      bclk_s3_q      <= 1'b0;
      lr_s1_q        <= 1'b0;
      lr_s2_q        <= 1'b0;
      sd_s1_q        <= 1'b0;
      sd_s2_q        <= 1'b0;
      bit_cnt_q      <= '0;
      chan_q         <= 1'b0;
      lr_prev_q      <= 1'b0;
      shift_q        <= '0;
      left_hold_q    <= '0;
      left_ok_q      <= 1'b0;
      locked_q       <= 1'b0;
      left_data_q    <= '0;
      right_data_q   <= '0;
      sample_valid_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      bclk_s1_q      <= i2s.bclk;
      bclk_s2_q      <= bclk_s1_q;
      bclk_s3_q      <= bclk_s2_q;
      lr_s1_q        <= i2s.lrclk;
      lr_s2_q        <= lr_s1_q;
      sd_s1_q        <= i2s.sdata;
      sd_s2_q        <= sd_s1_q;
      bit_cnt_q      <= bit_cnt_d;
      chan_q         <= chan_d;
      lr_prev_q      <= lr_prev_d;
      shift_q        <= shift_d;
      left_hold_q    <= left_hold_d;
      left_ok_q      <= left_ok_d;
      locked_q       <= locked_d;
      left_data_q    <= left_data_d;
      right_data_q   <= right_data_d;
      sample_valid_q <= sample_valid_d;
      err_short_q    <= err_short_d;
    end
  end

  assign i2s.left_data    = left_data_q;
  assign i2s.right_data   = right_data_q;
  assign i2s.sample_valid = sample_valid_q;
  assign i2s.err_short    = err_short_q;
  assign i2s.locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: self-checking bench for i2s_rx. Streams of whole I2S slots are
// serialized Philips-style; a slot-level reference model predicts the
// sequence of sample_valid / err_short events and the captured words.
module tb_i2s_rx;

  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n;

  i2s_rx_if #(.DATA_W(DATA_W)) i2s ();

  i2s_rx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i2s   (i2s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        is_err;
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;

  typedef struct {
    logic        err;
    logic        val;
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } obs_t;

  typedef struct {
    int          len;
    logic [31:0] lv;
    logic [31:0] rv;
    int          frames;
    logic [15:0] el;
    logic [15:0] er;
    int          ev;
    int          ee;
  } vec_t;

  ev_t         exp_q[$];
  obs_t        obs_q[$];
  int          s_len[$];
  logic        s_ch[$];
  logic [31:0] s_val[$];
  logic        model_locked;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe together with the data it presents.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (i2s.sample_valid === 1'b1 || i2s.err_short === 1'b1))
      obs_q.push_back('{i2s.err_short, i2s.sample_valid, i2s.left_data, i2s.right_data, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  task automatic clear_slots();
    s_len.delete();
    s_ch.delete();
    s_val.delete();
  endtask

  task automatic add_slot(input logic ch, input int len, input logic [31:0] val);
    s_ch.push_back(ch);
    s_len.push_back(len);
    s_val.push_back(val);
  endtask

  // Slot-level model: a slot is captured only if a word-select change opened
  // it while locked; at its closing boundary it yields either a word (top 16
  // bits) or a short-slot error. Left words wait for a following right word.
  task automatic build_model(input int reset_slot);
    logic        lr_prev, cap, left_ok, c;
    logic [15:0] hold, w;
    logic [31:0] v;
    int          n;
    n = s_len.size();
    lr_prev = 1'b0; cap = 1'b0; left_ok = 1'b0; hold = 16'h0;
    for (int i = 0; i <= n; i++) begin
      c = (i == n) ? ~s_ch[n-1] : s_ch[i];
      if (c != lr_prev) begin
        if (cap) begin
          if (s_len[i-1] >= 16) begin
            v = s_val[i-1] >> (s_len[i-1] - 16);
            w = v[15:0];
            if (!s_ch[i-1]) begin
              hold = w;
              left_ok = 1'b1;
            end else if (left_ok) begin
              exp_q.push_back('{1'b0, hold, w});
              left_ok = 1'b0;
            end
          end else begin
            exp_q.push_back('{1'b1, 16'h0, 16'h0});
            if (!s_ch[i-1]) left_ok = 1'b0;
          end
        end
        lr_prev = c;
        cap = 1'b1;
      end
      if (i == reset_slot) begin
        lr_prev = 1'b0; cap = 1'b0; left_ok = 1'b0; hold = 16'h0;
      end
    end
    model_locked = cap;
  endtask

  task automatic compare_events(input int base);
    int   n_obs;
    obs_t o;
    n_obs = obs_q.size() - base;
    check("event_count", 32'(n_obs), 32'(exp_q.size()));
    for (int k = 0; k < n_obs && k < exp_q.size(); k++) begin
      o = obs_q[base + k];
      check("event_kind", {30'd0, o.val, o.err}, {30'd0, ~exp_q[k].is_err, exp_q[k].is_err});
      if (!exp_q[k].is_err) begin
        check("left_data", 32'(o.l), 32'(exp_q[k].l));
        check("right_data", 32'(o.r), 32'(exp_q[k].r));
      end
    end
    exp_q.delete();
  endtask

  // Serialize the slot list (MSB one BCLK after the word-select change) plus
  // a one-bit pad slot that closes the last real slot. BCLK = clk/4.
  task automatic run_stream(input int reset_slot, input int phase, output int base_o);
    logic lr_p[$];
    logic bit_p[$];
    int   start_of[$];
    int   rp;
    base_o = obs_q.size();
    build_model(reset_slot);
    for (int i = 0; i < s_len.size(); i++) begin
      start_of.push_back(lr_p.size());
      for (int b = 0; b < s_len[i]; b++) begin
        lr_p.push_back(s_ch[i]);
        bit_p.push_back(s_val[i][s_len[i]-1-b]);
      end
    end
    lr_p.push_back(~s_ch[s_len.size()-1]);
    rp = -1;
    if (reset_slot >= 0) rp = start_of[reset_slot] + 9;
    repeat (phase + 1) @(negedge clk);
    for (int p = 0; p < lr_p.size(); p++) begin
      i2s.bclk  = 1'b0;
      i2s.lrclk = lr_p[p];
      i2s.sdata = (p == 0) ? 1'b0 : bit_p[p-1];
      repeat (2) @(negedge clk);
      i2s.bclk = 1'b1;
      repeat (2) @(negedge clk);
      if (p == 4 && reset_slot < 0 && s_ch[0] == 1'b0)
        check("unlocked_before_boundary", 32'(i2s.locked), 32'd0);
      if (p == rp) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left", 32'(i2s.left_data), 32'd0);
        check("rst_right", 32'(i2s.right_data), 32'd0);
        check("rst_valid", 32'(i2s.sample_valid), 32'd0);
        check("rst_err", 32'(i2s.err_short), 32'd0);
        check("rst_locked", 32'(i2s.locked), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("locked_after_reset", 32'(i2s.locked), 32'd0);
      end
    end
    i2s.bclk = 1'b0;
    repeat (8) @(negedge clk);
    compare_events(base_o);
    check("locked_end", 32'(i2s.locked), 32'(model_locked));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i2s.bclk = 1'b0; i2s.lrclk = 1'b0; i2s.sdata = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic int count_kind(input int base, input bit want_err);
    int n = 0;
    for (int k = base; k < obs_q.size(); k++)
      if ((want_err ? obs_q[k].err : obs_q[k].val) === 1'b1) n++;
    return n;
  endfunction

  initial begin
    vec_t tbl[6];
    int   lens[9];
    int   base, prev, n;
    logic ch0;

    tbl[0] = '{16, 32'h0000_1234, 32'h0000_EDCC, 3, 16'h1234, 16'hEDCC, 2, 0};
    tbl[1] = '{32, 32'h8001_FFFF, 32'h7FFE_0000, 2, 16'h8001, 16'h7FFE, 1, 0};
    tbl[2] = '{12, 32'h0000_0ABC, 32'h0000_0DEF, 2, 16'h0000, 16'h0000, 0, 3};
    tbl[3] = '{16, 32'h0000_8000, 32'h0000_7FFF, 2, 16'h8000, 16'h7FFF, 1, 0};
    tbl[4] = '{20, 32'h000A_BCDE, 32'h0001_2345, 2, 16'hABCD, 16'h1234, 1, 0};
    tbl[5] = '{15, 32'h0000_7FFF, 32'h0000_1234, 2, 16'h0000, 16'h0000, 0, 3};
    lens = '{12, 14, 15, 16, 16, 16, 17, 24, 32};

    rst_n = 1'b0;
    i2s.bclk = 1'b0; i2s.lrclk = 1'b0; i2s.sdata = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_left", 32'(i2s.left_data), 32'd0);
    check("reset_right", 32'(i2s.right_data), 32'd0);
    check("reset_valid", 32'(i2s.sample_valid), 32'd0);
    check("reset_err", 32'(i2s.err_short), 32'd0);
    check("reset_locked", 32'(i2s.locked), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of uniform-slot streams starting on a left slot.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      clear_slots();
      for (int f = 0; f < tbl[t].frames; f++) begin
        add_slot(1'b0, tbl[t].len, tbl[t].lv);
        add_slot(1'b1, tbl[t].len, tbl[t].rv);
      end
      run_stream(-1, 0, base);
      check("tbl_valid_count", 32'(count_kind(base, 1'b0)), 32'(tbl[t].ev));
      check("tbl_err_count", 32'(count_kind(base, 1'b1)), 32'(tbl[t].ee));
      check("tbl_left", 32'(i2s.left_data), 32'(tbl[t].el));
      check("tbl_right", 32'(i2s.right_data), 32'(tbl[t].er));
    end

    // One frame of 12-bit slots inside a run of 16-bit frames.
    do_reset();
    clear_slots();
    add_slot(1'b0, 16, 32'h1111); add_slot(1'b1, 16, 32'h2222);
    add_slot(1'b0, 12, 32'h0333); add_slot(1'b1, 12, 32'h0444);
    add_slot(1'b0, 16, 32'h5555); add_slot(1'b1, 16, 32'h6666);
    add_slot(1'b0, 16, 32'h7777); add_slot(1'b1, 16, 32'h8888);
    run_stream(-1, 1, base);
    check("short_err_count", 32'(count_kind(base, 1'b1)), 32'd2);
    check("short_valid_count", 32'(count_kind(base, 1'b0)), 32'd2);
    check("short_left", 32'(i2s.left_data), 32'h7777);
    check("short_right", 32'(i2s.right_data), 32'h8888);

    // Reset during bit 8 of a left slot, then relock.
    do_reset();
    clear_slots();
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 16, 32'(16'h1111 * (f + 1)));
      add_slot(1'b1, 16, 32'(16'hA5A0 + f));
    end
    run_stream(4, 2, base);
    check("relock_left", 32'(i2s.left_data), 32'h4444);
    check("relock_right", 32'(i2s.right_data), 32'hA5A3);

    // Extreme values with all four BCLK-to-clk phases; constant 128-clk spacing.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      clear_slots();
      for (int f = 0; f < 4; f++) begin
        add_slot(1'b0, 16, 32'h8000);
        add_slot(1'b1, 16, 32'h7FFF);
      end
      run_stream(-1, ph, base);
      prev = -1;
      for (int k = base; k < obs_q.size(); k++) begin
        if (obs_q[k].val === 1'b1) begin
          if (prev >= 0) check("valid_spacing", 32'(obs_q[k].cyc - prev), 32'd128);
          prev = obs_q[k].cyc;
        end
      end
      check("phase_left", 32'(i2s.left_data), 32'h8000);
      check("phase_right", 32'(i2s.right_data), 32'h7FFF);
    end

    // Random slot lengths, data, start channel and phase against the model.
    for (int r = 0; r < 25; r++) begin
      do_reset();
      clear_slots();
      n = $urandom_range(10, 5);
      ch0 = 1'($urandom_range(1, 0));
      for (int i = 0; i < n; i++)
        add_slot(ch0 ^ 1'(i % 2), lens[$urandom_range(8, 0)], $urandom);
      run_stream(-1, $urandom_range(3, 0), base);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Philips-format I2S receiver: the capture counterpart to the on-chip 16-bit I2S transmitter. It takes BCLK, LRCLK and SDATA from an external master (codec, ADC, or the transmitter looped back) and oversamples them on the 12 MHz system clock. It deserializes one 16-bit signed word per channel and presents each completed stereo pair with a one-cycle valid strobe. Intended placement: at the top level, beside the DDS/transmitter path, feeding loopback checkers or downstream DSP.

## Interface
- DATA_W, 16, bits captured per channel (MSB first); slot may be longer, extra bits ignored
- clk  in  1  system clock, 12 MHz; sole clock of the block
- rst_n  in  1  synchronous, active-low reset
- bclk  in  1  asynchronous serial bit clock from master; max frequency clk/4
- lrclk  in  1  asynchronous word select; 0 = left, 1 = right
- sdata  in  1  asynchronous serial data, MSB first
- left_data  out  DATA_W  signed left sample of last completed frame
- right_data  out  DATA_W  signed right sample of last completed frame
- sample_valid  out  1  one-cycle pulse: left_data/right_data updated
- err_short  out  1  one-cycle pulse: slot ended before DATA_W bits captured
- locked  out  1  high once a channel boundary has been seen since reset

## Operation
- Input sync: bclk, lrclk, sdata each pass through two flops (s1, s2); a third flop on bclk (s3) gives bclk_rise = s2 & ~s3. All three inputs share identical delay, so they remain aligned.
- All capture happens only in cycles where bclk_rise = 1. Falling edges are ignored.
- State: bit_cnt (0..DATA_W), chan, lr_prev, shift reg (DATA_W), left_hold, left_ok, locked.
- On a bclk_rise with lrclk_s2 == lr_prev (mid-slot):
  - if locked and bit_cnt < DATA_W: shift in sdata_s2 and increment bit_cnt;
  - when bit_cnt becomes DATA_W, the word completes.
  - Bits beyond DATA_W are discarded until the next boundary.
- On a bclk_rise with lrclk_s2 != lr_prev (boundary; Philips format, this bit is the previous slot's last bit):
  - first, if locked and bit_cnt < DATA_W, shift in the bit; completion is checked as above;
  - if locked and the resulting count < DATA_W: pulse err_short and discard the word; if the discarded word was left, clear left_ok;
  - then set bit_cnt = 0, chan = lrclk_s2, lr_prev = lrclk_s2, locked = 1.
  - The MSB of the new slot arrives on the next rise.
- The first boundary after reset only sets locked. The partial slot before it is discarded with no error.
- Word completion, chan = 0: left_hold <= word, left_ok <= 1.
- Word completion, chan = 1:
  - if left_ok: left_data <= left_hold, right_data <= word, pulse sample_valid, clear left_ok;
  - else: discard silently (a right word without a preceding left).
- Completion and boundary in the same rise (exact DATA_W-bit slot) are both processed: completion first, then reset of the counter.
- Reset mid-frame clears everything. The next boundary relocks, and the next full left+right pair produces the first valid.

## Timing
- Reset values: left_data = 0, right_data = 0, sample_valid = 0, err_short = 0, locked = 0. All sync flops, bit_cnt, lr_prev, left_ok, shift and left_hold also reset to 0.
- Input latency: external BCLK rising edge to the capturing bclk_rise cycle is 2–3 clk cycles, because of synchronizer phase.
- sample_valid, err_short, left_data, right_data and locked are registered. They change in the clk cycle after the capturing bclk_rise cycle.
- sample_valid is high for exactly 1 clk cycle per completed frame. Data is stable from that cycle until the next pulse.
- Throughput: one frame per 2×slot BCLK periods. No backpressure; the consumer must accept each pulse.
- BCLK high and low must each last ≥ 2 clk cycles. Faster BCLK is unsupported, and the resulting behaviour is undefined.

## Test plan
- Nominal loopback:
  - stimulus: BCLK = 3 MHz (toggle every 2 clk), 16-bit slots, left = 0x1234, right = 0xEDCC repeated;
  - response: after the first full frame, sample_valid pulses once per 32 BCLK, left_data = 0x1234, right_data = 0xEDCC, err_short never asserts.
- Lock after reset:
  - stimulus: release rst_n mid-right-slot;
  - response: locked = 0 until the next LRCLK edge; the first sample_valid comes only after one complete left+right pair; no err_short before lock.
- Long slot:
  - stimulus: 32-bit slots carrying 0x8001_FFFF left, 0x7FFE_0000 right;
  - response: left_data = 0x8001, right_data = 0x7FFE, lower 16 bits ignored.
- Short slot:
  - stimulus: 12-bit slots for one frame, then normal 16-bit frames;
  - response: err_short pulses at each short boundary, no sample_valid for that frame, correct data on the next full frame.
- Reset mid-frame:
  - stimulus: assert rst_n = 0 for 3 cycles during bit 8 of left;
  - response: all outputs 0 during reset, locked = 0 after reset, correct values on the first full frame after relock.
- Extremes and edge phase:
  - stimulus: left = 0x8000, right = 0x7FFF, with BCLK phase swept over all 4 clk alignments;
  - response: identical captured values, sample_valid spacing constant at 128 clk.
